ctrl_pipe_regs: RTL and testbench
=================================

# ctrl_pipe_regs

Pipeline control carrier and hazard unit for the 5-stage MIPS core. Takes the decoded control bits produced in ID and carries them through the ID/EX, EX/MEM and MEM/WB boundaries. Each signal is delivered to the stage that uses it. The block also detects load-use hazards and taken branches/jumps, and drives the stall, flush and bubble-insertion controls for the PC and IF/ID registers. A saturating counter records inserted bubbles.

## Interface
- CNT_W, 16, width of the bubble counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- id_reg_dst, id_reg_write, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_jump  in  1 each  decoded controls in ID
- id_alu_op  in  2  decoded ALU op in ID
- id_rs, id_rt, id_rd  in  5 each  register fields of instruction in ID
- ex_zero  in  1  ALU zero flag from EX (combinational)
- ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read  out  1 each  ID/EX control
- ex_alu_op  out  2  ID/EX ALU op
- ex_rt, ex_wreg  out  5 each  ID/EX rt; destination (rd if reg_dst else rt)
- mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg  out  1 each  EX/MEM control
- mem_wreg  out  5  EX/MEM destination
- wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB control
- wb_wreg  out  5  MEM/WB destination
- pc_write, ifid_write  out  1 each  enable PC / IF/ID update (low = stall)
- ifid_flush  out  1  zero IF/ID on next edge
- pc_src  out  1  select branch target (ex_branch & ex_zero)
- jump_sel  out  1  select jump target (id_jump & no stall & no pc_src)
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted into ID/EX

## Operation
- Stages ID/EX, EX/MEM and MEM/WB are registers. EX/MEM copies the ID/EX fields; MEM/WB copies the EX/MEM fields.
- ex_wreg is latched as id_reg_dst ? id_rd : id_rt.
- Load-use hazard is computed combinationally:
  - luh = ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- Branch taken: pc_src = ex_branch & ex_zero.
- Priority is pc_src over luh over id_jump.
  - pc_src=1: ifid_flush=1, pc_write=1, ifid_write=1. Bubble loaded into ID/EX, so the instruction in ID is squashed. luh is ignored.
  - luh=1 (no pc_src): pc_write=0, ifid_write=0, ifid_flush=0. Bubble loaded into ID/EX. EX/MEM and MEM/WB advance normally.
  - id_jump=1 (neither of the above): jump_sel=1, ifid_flush=1. The jump's own ID controls enter ID/EX as decoded. The jump writes no register and no memory.
  - Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, jump_sel=0.
- Bubble definition: all ID/EX control bits are 0, alu_op=00, ex_rt=0, ex_wreg=0.
- bubble_cnt increments by 1 per bubble. It holds at 2^CNT_W-1 and never wraps.
- Reset (rst=0 at an edge):
  - All pipeline registers are cleared to bubble.
  - bubble_cnt=0.
  - Reset overrides any hazard in the same cycle.
  - Reset does not count as a bubble.
- Combinational outputs while rst=0: pc_write=1, ifid_write=1, ifid_flush=0, pc_src=0, jump_sel=0, regardless of inputs.

## Timing
- Control latency: ID inputs appear on ex_* 1 cycle later, on mem_* 2 cycles later, on wb_* 3 cycles later.
- Hazard outputs (pc_write, ifid_write, ifid_flush, pc_src, jump_sel) are combinational in the same cycle as their cause.
- Load-use stall lasts exactly 1 cycle. After the bubble, ex_mem_read=0, so luh drops and the stalled instruction proceeds.
- A taken branch costs 2 squashed slots: the IF/ID flush and the ID/EX bubble.
- A jump costs 1 squashed slot: the IF/ID flush.
- bubble_cnt updates on the same edge that loads the bubble.

## Test plan
- Reset: hold rst=0 for 2 cycles with random ID inputs -> every registered output is 0, bubble_cnt=0, pc_write=1. Release rst -> the first ID word reaches ex_* after 1 cycle.
- Propagation: LW controls (reg_write=1, alu_src=1, mem_read=1, mem_to_reg=1, alu_op=11, rt=5) -> ex_wreg=5 at T+1, mem_mem_read=1 at T+2, wb_reg_write=1 at T+3.
- Load-use: LW rt=7 in EX while ID has rs=7 -> pc_write=0 and ifid_write=0 for 1 cycle, ID/EX bubble, bubble_cnt=1. Same case with rt=0 -> no stall.
- Branch vs load-use: ex_branch=1, ex_zero=1 while luh is also true -> pc_src=1, ifid_flush=1, pc_write=1, 1 bubble counted, no stall.
- Jump: id_jump=1 with no hazards -> jump_sel=1 and ifid_flush=1 for 1 cycle, bubble_cnt unchanged.
- Saturation: CNT_W=2, force 5 consecutive load-use bubbles -> bubble_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/ctrl_pipe_regs.sv
// Control-word carrier through ID/EX, EX/MEM and MEM/WB for the 5-stage MIPS core,
// plus load-use / branch / jump hazard control and a saturating bubble counter.
module ctrl_pipe_regs #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_alu_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic [1:0]       id_alu_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_zero,
    output logic             ex_reg_dst,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_mem_read,
    output logic [1:0]       ex_alu_op,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_wreg,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_reg_write,
    output logic             mem_mem_to_reg,
    output logic [4:0]       mem_wreg,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [4:0]       wb_wreg,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             pc_src,
    output logic             jump_sel,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic ex_reg_write;
    logic ex_mem_write;
    logic ex_mem_to_reg;
    logic luh;
    logic bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign luh = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    // Hazard resolution: taken branch beats load-use, which beats jump
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pc_src     = 1'b0;
        jump_sel   = 1'b0;
        bubble     = 1'b0;
        if (rst) begin
            if (ex_branch && ex_zero) begin
                pc_src     = 1'b1;
                ifid_flush = 1'b1;
                bubble     = 1'b1;
            end else if (luh) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                bubble     = 1'b1;
            end else if (id_jump) begin
                jump_sel   = 1'b1;
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_reg_dst     <= 1'b0;
            ex_alu_src     <= 1'b0;
            ex_branch      <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_alu_op      <= 2'b00;
            ex_rt          <= 5'd0;
            ex_wreg        <= 5'd0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_wreg       <= 5'd0;
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_wreg        <= 5'd0;
            bubble_cnt     <= '0;
        end else begin
            // ID/EX boundary: a bubble squashes the whole control word
            if (bubble) begin
                ex_reg_dst    <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_branch     <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_alu_op     <= 2'b00;
                ex_rt         <= 5'd0;
                ex_wreg       <= 5'd0;
                bubble_cnt    <= sat_inc(bubble_cnt);
            end else begin
                ex_reg_dst    <= id_reg_dst;
                ex_alu_src    <= id_alu_src;
                ex_branch     <= id_branch;
                ex_mem_read   <= id_mem_read;
                ex_mem_write  <= id_mem_write;
                ex_reg_write  <= id_reg_write;
                ex_mem_to_reg <= id_mem_to_reg;
                ex_alu_op     <= id_alu_op;
                ex_rt         <= id_rt;
                ex_wreg       <= id_reg_dst ? id_rd : id_rt;
            end
            // EX/MEM boundary
            mem_mem_read   <= ex_mem_read;
            mem_mem_write  <= ex_mem_write;
            mem_reg_write  <= ex_reg_write;
            mem_mem_to_reg <= ex_mem_to_reg;
            mem_wreg       <= ex_wreg;
            // MEM/WB boundary
            wb_reg_write   <= mem_reg_write;
            wb_mem_to_reg  <= mem_mem_to_reg;
            wb_wreg        <= mem_wreg;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed bench for ctrl_pipe_regs: a reference model pushes the expected pipeline
// state per cycle into a scoreboard queue that is popped after each rising edge.
module tb_ctrl_pipe_regs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       id_reg_dst = 0, id_reg_write = 0, id_alu_src = 0, id_mem_read = 0;
    logic       id_mem_write = 0, id_mem_to_reg = 0, id_branch = 0, id_jump = 0;
    logic [1:0] id_alu_op = 0;
    logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
    logic       ex_zero = 0;

    logic       ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic       mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
    logic       wb_reg_write, wb_mem_to_reg;
    logic       pc_write, ifid_write, ifid_flush, pc_src, jump_sel;
    logic [15:0] bubble_cnt;

    logic       s_ex_reg_dst, s_ex_alu_src, s_ex_branch, s_ex_mem_read;
    logic [1:0] s_ex_alu_op;
    logic [4:0] s_ex_rt, s_ex_wreg, s_mem_wreg, s_wb_wreg;
    logic       s_mem_mem_read, s_mem_mem_write, s_mem_reg_write, s_mem_mem_to_reg;
    logic       s_wb_reg_write, s_wb_mem_to_reg;
    logic       s_pc_write, s_ifid_write, s_ifid_flush, s_pc_src, s_jump_sel;
    logic [1:0] s_bubble_cnt;

    ctrl_pipe_regs #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_alu_op(ex_alu_op), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_wreg(mem_wreg),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_wreg(wb_wreg),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .pc_src(pc_src), .jump_sel(jump_sel), .bubble_cnt(bubble_cnt)
    );

    ctrl_pipe_regs #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_reg_dst(s_ex_reg_dst), .ex_alu_src(s_ex_alu_src), .ex_branch(s_ex_branch),
        .ex_mem_read(s_ex_mem_read), .ex_alu_op(s_ex_alu_op), .ex_rt(s_ex_rt), .ex_wreg(s_ex_wreg),
        .mem_mem_read(s_mem_mem_read), .mem_mem_write(s_mem_mem_write),
        .mem_reg_write(s_mem_reg_write), .mem_mem_to_reg(s_mem_mem_to_reg), .mem_wreg(s_mem_wreg),
        .wb_reg_write(s_wb_reg_write), .wb_mem_to_reg(s_wb_mem_to_reg), .wb_wreg(s_wb_wreg),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .pc_src(s_pc_src), .jump_sel(s_jump_sel), .bubble_cnt(s_bubble_cnt)
    );

    typedef struct packed {
        logic       reg_dst, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg;
        logic [1:0] alu_op;
        logic [4:0] rt, wreg;
    } ex_t;

    typedef struct packed {
        ex_t         ex;
        logic [8:0]  mem;   // mem_read, mem_write, reg_write, mem_to_reg, wreg
        logic [6:0]  wb;    // reg_write, mem_to_reg, wreg
        logic [15:0] c16;
        logic [1:0]  c2;
    } exp_t;

    exp_t        sb[$];
    ex_t         m_ex  = '0;
    logic [8:0]  m_mem = '0;
    logic [6:0]  m_wb  = '0;
    logic [15:0] m_c16 = '0;
    logic [1:0]  m_c2  = '0;

    int checks = 0;
    int errors = 0;
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_id(input logic rd_sel, input logic rw, input logic asrc, input logic mr,
                          input logic mw, input logic m2r, input logic br, input logic jmp,
                          input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        id_reg_dst = rd_sel; id_reg_write = rw; id_alu_src = asrc; id_mem_read = mr;
        id_mem_write = mw; id_mem_to_reg = m2r; id_branch = br; id_jump = jmp;
        id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    // One clock: check the combinational hazard outputs, then the registered state.
    task automatic step(input logic r, input logic z);
        logic luh_m, ps_m, bub;
        logic e_pw, e_iw, e_fl, e_ps, e_js;
        ex_t  nx;
        exp_t e;
        @(negedge clk);
        rst = r;
        ex_zero = z;
        #1;
        luh_m = m_ex.mem_read && (m_ex.rt != 0) && (m_ex.rt == id_rs || m_ex.rt == id_rt);
        ps_m  = m_ex.branch && z;
        {e_pw, e_iw, e_fl, e_ps, e_js} = 5'b11000;
        if (r) begin
            if (ps_m)         {e_pw, e_iw, e_fl, e_ps, e_js} = 5'b11110;
            else if (luh_m)   {e_pw, e_iw, e_fl, e_ps, e_js} = 5'b00000;
            else if (id_jump) {e_pw, e_iw, e_fl, e_ps, e_js} = 5'b11101;
        end
        chk("pc_write",   {31'd0, pc_write},   {31'd0, e_pw});
        chk("ifid_write", {31'd0, ifid_write}, {31'd0, e_iw});
        chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, e_fl});
        chk("pc_src",     {31'd0, pc_src},     {31'd0, e_ps});
        chk("jump_sel",   {31'd0, jump_sel},   {31'd0, e_js});
        bub = r && (ps_m || luh_m);
        nx = '0;
        if (r && !bub) begin
            nx.reg_dst = id_reg_dst; nx.alu_src = id_alu_src; nx.branch = id_branch;
            nx.mem_read = id_mem_read; nx.mem_write = id_mem_write;
            nx.reg_write = id_reg_write; nx.mem_to_reg = id_mem_to_reg;
            nx.alu_op = id_alu_op; nx.rt = id_rt;
            nx.wreg = id_reg_dst ? id_rd : id_rt;
        end
        if (!r) begin
            m_wb = '0; m_mem = '0; m_c16 = '0; m_c2 = '0;
        end else begin
            m_wb  = m_mem[6:0];
            m_mem = {m_ex.mem_read, m_ex.mem_write, m_ex.reg_write, m_ex.mem_to_reg, m_ex.wreg};
            if (bub) begin
                if (m_c16 != 16'hFFFF) m_c16 = m_c16 + 16'd1;
                if (m_c2 != 2'd3) m_c2 = m_c2 + 2'd1;
            end
        end
        m_ex = nx;
        e = '{ex: m_ex, mem: m_mem, wb: m_wb, c16: m_c16, c2: m_c2};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("ex_word", {16'd0, ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read, ex_alu_op, ex_rt, ex_wreg},
            {16'd0, e.ex.reg_dst, e.ex.alu_src, e.ex.branch, e.ex.mem_read, e.ex.alu_op, e.ex.rt, e.ex.wreg});
        chk("mem_word", {23'd0, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_wreg},
            {23'd0, e.mem});
        chk("wb_word", {25'd0, wb_reg_write, wb_mem_to_reg, wb_wreg}, {25'd0, e.wb});
        chk("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, e.c16});
        chk("sat_cnt", {30'd0, s_bubble_cnt}, {30'd0, e.c2});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random ID activity
        for (int i = 0; i < 2; i++) begin
            set_id($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            step(1'b0, 1'($urandom_range(0, 1)));
        end
        chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("rst_pcw", {31'd0, pc_write}, 32'd1);

        // R-type right after reset release: rd selected as destination
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd3);
        step(1'b1, 1'b0);
        chk("rtype_wreg", {27'd0, ex_wreg}, 32'd3);

        // LW propagation through all three boundaries
        set_id(0, 1, 1, 1, 0, 1, 0, 0, 2'b11, 5'd1, 5'd5, 5'd0);
        step(1'b1, 1'b0);
        chk("lw_ex_wreg", {27'd0, ex_wreg}, 32'd5);
        nop();
        step(1'b1, 1'b0);
        chk("lw_mem_rd", {31'd0, mem_mem_read}, 32'd1);
        step(1'b1, 1'b0);
        chk("lw_wb_rw", {31'd0, wb_reg_write}, 32'd1);

        // Load-use on rs: one stall cycle, then the dependent instruction proceeds
        set_id(0, 1, 1, 1, 0, 1, 0, 0, 2'b11, 5'd1, 5'd7, 5'd0);
        step(1'b1, 1'b0);
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 5'd7, 5'd2, 5'd4);
        step(1'b1, 1'b0);
        chk("luh_cnt", {16'd0, bubble_cnt}, 32'd1);
        chk("luh_bubble", {31'd0, ex_mem_read}, 32'd0);
        step(1'b1, 1'b0);
        chk("luh_resume", {27'd0, ex_wreg}, 32'd4);

        // Load into r0 never stalls
        set_id(0, 1, 1, 1, 0, 1, 0, 0, 2'b11, 5'd1, 5'd0, 5'd0);
        step(1'b1, 1'b0);
        nop();
        step(1'b1, 1'b0);
        chk("r0_cnt", {16'd0, bubble_cnt}, 32'd1);

        // Taken branch while load-use also holds: branch wins
        set_id(0, 0, 0, 1, 0, 0, 1, 0, 2'b01, 5'd3, 5'd9, 5'd0);
        step(1'b1, 1'b0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd9, 5'd0, 5'd0);
        step(1'b1, 1'b1);
        chk("br_cnt", {16'd0, bubble_cnt}, 32'd2);

        // Branch not taken
        set_id(0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 5'd3, 5'd4, 5'd0);
        step(1'b1, 1'b0);
        nop();
        step(1'b1, 1'b0);

        // Jump with no hazard, then a jump held off by load-use
        set_id(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b0);
        chk("jmp_cnt", {16'd0, bubble_cnt}, 32'd2);
        set_id(0, 1, 1, 1, 0, 1, 0, 0, 2'b11, 5'd1, 5'd7, 5'd0);
        step(1'b1, 1'b0);
        set_id(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 5'd7, 5'd0, 5'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Saturation on the 2-bit counter after a fresh reset
        nop();
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_id(0, 1, 1, 1, 0, 1, 0, 0, 2'b11, 5'd1, 5'd7, 5'd0);
            step(1'b1, 1'b0);
            set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd7, 5'd0, 5'd0);
            step(1'b1, 1'b0);
            chk("sat_seq", {30'd0, s_bubble_cnt}, {30'd0, sat_exp[i]});
        end

        // Reset overrides a pending load-use and is not counted
        set_id(0, 1, 1, 1, 0, 1, 0, 0, 2'b11, 5'd1, 5'd7, 5'd0);
        step(1'b1, 1'b0);
        set_id(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 5'd7, 5'd0, 5'd0);
        step(1'b0, 1'b1);
        chk("rst_ovr_cnt", {16'd0, bubble_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
